// File: rtl/sop_scan_ctrl_if.sv
// Bus between the SoP scan sequencer and its user / SoP datapath.
// slave  = the sequencer itself, master = the environment that starts
// sweeps, supplies the golden table and hosts the SoP block.
interface sop_scan_ctrl_if #(
    parameter int N_IN = 4
);
    localparam int TW = 1 << N_IN;

    logic            start;
    logic [TW-1:0]   expected;
    logic [N_IN-1:0] sop_in;
    logic            sop_out;
    logic            busy;
    logic            done;
    logic [TW-1:0]   table_out;
    logic            pass;
    logic [N_IN:0]   err_count;
    logic [N_IN-1:0] mismatch_idx;

    modport master (
        output start, expected, sop_out,
        input  sop_in, busy, done, table_out, pass, err_count, mismatch_idx
    );

    modport slave (
        input  start, expected, sop_out,
        output sop_in, busy, done, table_out, pass, err_count, mismatch_idx
    );
endinterface

// File: rtl/sop_scan_ctrl.sv
// In-system truth-table sweep of a combinational SoP block.
// Walks every input vector in ascending order, holds each for SETTLE+1
// cycles, samples o1 on the last hold cycle and compares the captured
// table against a golden table latched when the sweep was accepted.
module sop_scan_ctrl #(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic           clk,
    input logic           rst,
    sop_scan_ctrl_if.slave bus
);
    localparam int TW = 1 << N_IN;
    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [N_IN-1:0] IDX_ONE  = N_IN'(1);
    localparam logic [N_IN-1:0] IDX_LAST = N_IN'(TW - 1);
    localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] idx_q;
    logic [CW-1:0]   cnt_q;
    logic [TW-1:0]   exp_q;
    logic [TW-1:0]   table_q;
    logic [N_IN:0]   err_q;
    logic [N_IN-1:0] midx_q;
    logic            pass_q;
    logic            busy_q;
    logic            done_q;

    logic            accept;
    logic            sample;
    logic            last;
    logic            bit_err;
    logic [TW-1:0]   table_nx;

    // Next state plus the per-cycle decode shared with the datapath
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        sample   = 1'b0;
        last     = (idx_q == IDX_LAST);
        bit_err  = (bus.sop_out != exp_q[idx_q]);
        // table was cleared on accept, so OR-ing in the sample is enough
        table_nx = table_q | ({{(TW-1){1'b0}}, bus.sop_out} << idx_q);
        case (state_q)
            S_IDLE: begin
                accept = bus.start;
                if (accept) state_d = S_HOLD;
            end
            S_HOLD: begin
                sample = (cnt_q == '0);
                if (sample && last) state_d = S_DONE;
            end
            S_DONE: begin
                // DONE is a single cycle; a start here restarts immediately
                accept  = bus.start;
                state_d = accept ? S_HOLD : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Sweep datapath: index/settle counter, capture and compare results
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            table_q <= '0;
            err_q   <= '0;
            midx_q  <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                exp_q   <= bus.expected;
                table_q <= '0;
                err_q   <= '0;
                midx_q  <= '0;
                pass_q  <= 1'b0;
                idx_q   <= '0;
                cnt_q   <= CNT_LOAD;
                busy_q  <= 1'b1;
            end else if (sample) begin
                table_q <= table_nx;
                if (bit_err) begin
                    err_q <= err_q + ERR_ONE;
                    if (err_q == '0) midx_q <= idx_q;
                end
                if (!last) begin
                    idx_q <= idx_q + IDX_ONE;
                    cnt_q <= CNT_LOAD;
                end else begin
                    // idx stays at TW-1 so sop_in holds the final vector
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                    pass_q <= (table_nx == exp_q);
                end
            end else if (state_q == S_HOLD) begin
                cnt_q <= cnt_q - CNT_ONE;
            end
        end
    end

    assign bus.sop_in       = idx_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.table_out    = table_q;
    assign bus.pass         = pass_q;
    assign bus.err_count    = err_q;
    assign bus.mismatch_idx = midx_q;

endmodule
